user_sw_debouncer: RTL and testbench
====================================

Name: user_sw_debouncer

Overview:
- Input-side conditioner for the board user switches.
- Takes the raw 4-bit DIP and 4-bit push-switch pads and synchronises them into iSysClk.
- Debounces each bit independently and outputs clean active-high levels, one-cycle press/release/change pulses, and a long-press level.
- Sits between the switch pads and the processor logic that drives the user LEDs.

Parameters:
pTICK_DIV, 50000, iSysClk cycles per debounce sample tick (1 ms at 50 MHz); must be ≥2
pSTABLE_TICKS, 10, consecutive ticks a differing input must persist before the clean state follows it; ≥1
pHOLD_TICKS, 1000, ticks a push must stay pressed before oPushHold asserts; ≥1
pPUSH_ACT_LOW, 1, 1 = push pad reads 0 when pressed; 0 = pad reads 1 when pressed

Ports:
iSysClk  in  1  system clock
iSysRstn  in  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously to iSysClk at system level
iUserDipSw  in  4  raw DIP pads, asynchronous
iUserPushSw  in  4  raw push pads, asynchronous
oDipSw  out  4  debounced DIP level
oDipChg  out  1  one-cycle pulse when any oDipSw bit changes
oPushSw  out  4  debounced pressed level, 1 = pressed regardless of pad polarity
oPushPress  out  4  one-cycle pulse per bit on press
oPushRelease  out  4  one-cycle pulse per bit on release
oPushHold  out  4  level, 1 while a bit has been pressed ≥ pHOLD_TICKS ticks

Behaviour:
- Reset (iSysRstn=0, async):
  - Clears the synchroniser flops, prescaler, all per-bit counters and all outputs to 0.
  - Push synchroniser flops reset to the released pad level (1 if pPUSH_ACT_LOW), so no spurious press follows reset.
  - Reset mid-debounce discards partial counts.
- Synchroniser:
  - 2 flops per bit.
  - Push bits are inverted after synchronisation when pPUSH_ACT_LOW=1.
  - The debounce logic sees only the second-stage value s[i].
- Prescaler:
  - Counts 0..pTICK_DIV-1 and wraps.
  - Tick is a 1-cycle strobe while count = pTICK_DIV-1.
  - Free-running from reset release.
- Per-bit debounce (8 identical instances, clean state c[i], counter n[i]):
  - s[i]==c[i]: n[i] <= 0 every cycle, whether or not a tick occurs.
  - s[i]!=c[i] and tick and n[i]==pSTABLE_TICKS-1: c[i] <= s[i], n[i] <= 0.
  - s[i]!=c[i] and tick otherwise: n[i] <= n[i]+1.
  - s[i]!=c[i] and no tick: hold n[i].
  - A glitch shorter than pSTABLE_TICKS ticks returns s to c, clears n, and produces no output change.
  - Counter width is clog2(pSTABLE_TICKS) with a minimum of 1; it never exceeds pSTABLE_TICKS-1.
- Latency:
  - Pad change to output change is 2 + (pSTABLE_TICKS-1)*pTICK_DIV + 1 cycles minimum.
  - Maximum is 2 + pSTABLE_TICKS*pTICK_DIV cycles.
- Edge outputs (all registered, same cycle as the c[i] update):
  - oPushPress[i]: c[i] 0→1.
  - oPushRelease[i]: c[i] 1→0.
  - oDipChg: any DIP c bit changes that cycle; multiple simultaneous DIP bits give a single pulse.
  - Bits are independent; several press/release pulses may coincide.
- DIP after reset:
  - oDipSw starts at 0.
  - A DIP set to 1 at reset therefore reaches 1 after normal debounce latency, with an oDipChg pulse. This is intended.
- Hold (per push bit, counter h[i], saturating):
  - Cleared while oPushSw[i]=0.
  - Increments on tick while oPushSw[i]=1.
  - oPushHold[i] registers to 1 on the tick where h[i] reaches pHOLD_TICKS, and stays 1 until release.
  - On release, oPushHold[i] clears in the same cycle that oPushSw[i] falls.
  - h[i] saturates at pHOLD_TICKS with no wrap.
- Steady-state outputs have no combinational path from the pads; every output is a flop.

Test Plan (pTICK_DIV=4, pSTABLE_TICKS=3, pHOLD_TICKS=5, pPUSH_ACT_LOW=1):
1. Reset with iUserPushSw=4'hF, iUserDipSw=0 → all outputs 0, and they stay 0 for 100 cycles after reset release.
2. Drive iUserPushSw[0]=0 and hold → oPushSw[0]=1 within 11..14 cycles; oPushPress[0] is a single 1-cycle pulse on that same cycle; no other bit changes.
3. Drive iUserPushSw[1] low for 6 cycles then high → oPushSw[1], oPushPress[1] and oPushRelease[1] all remain 0.
4. Keep push 0 pressed → oPushHold[0] rises exactly 5 ticks (20 cycles) after oPushSw[0] rose. Then release → oPushRelease[0] pulses and oPushHold[0] clears on the same cycle oPushSw[0] falls.
5. Set iUserDipSw 0→4'b0101 simultaneously → oDipSw=4'b0101 on a single cycle with exactly one oDipChg pulse.
6. Assert iUserPushSw[2]=0, then pulse iSysRstn low mid-count (~8 cycles later) → outputs clear immediately. After release, oPushSw[2] rises only after a full fresh 11..14-cycle debounce.

Source files
------------

// File: rtl/user_sw_debouncer.sv
// Board user-switch conditioner: synchronises the raw DIP and push pads into
// iSysClk, debounces every bit on a slow sample tick, and produces clean
// levels, one-cycle press/release/change pulses and a per-push long-press level.
// Every output comes straight from a flop so the pads never reach the
// processor logic combinationally.
module user_sw_debouncer #(
  parameter int pTICK_DIV     = 50000,
  parameter int pSTABLE_TICKS = 10,
  parameter int pHOLD_TICKS   = 1000,
  parameter bit pPUSH_ACT_LOW = 1'b1
) (
  input  logic       iSysClk,
  input  logic       iSysRstn,
  input  logic [3:0] iUserDipSw,
  input  logic [3:0] iUserPushSw,
  output logic [3:0] oDipSw,
  output logic       oDipChg,
  output logic [3:0] oPushSw,
  output logic [3:0] oPushPress,
  output logic [3:0] oPushRelease,
  output logic [3:0] oPushHold
);

  localparam int cDivW  = (pTICK_DIV > 1) ? $clog2(pTICK_DIV) : 1;
  localparam int cCntW  = (pSTABLE_TICKS > 1) ? $clog2(pSTABLE_TICKS) : 1;
  localparam int cHoldW = $clog2(pHOLD_TICKS + 1);

  localparam logic [cDivW-1:0]  cDivLast  = cDivW'(pTICK_DIV - 1);
  localparam logic [cCntW-1:0]  cCntLast  = cCntW'(pSTABLE_TICKS - 1);
  localparam logic [cHoldW-1:0] cHoldMax  = cHoldW'(pHOLD_TICKS);
  localparam logic [cHoldW-1:0] cHoldLast = cHoldW'(pHOLD_TICKS - 1);
  // Released pad level; the push synchroniser resets here so reset never looks like a press.
  localparam logic [3:0]        cPushIdle = {4{pPUSH_ACT_LOW}};

  logic [3:0]             dipMeta;
  logic [3:0]             dipSync;
  logic [3:0]             pushMeta;
  logic [3:0]             pushSync;
  logic [3:0]             pushLevel;
  logic [7:0]             sampled;

  logic [cDivW-1:0]       divCount;
  logic                   tick;

  logic [7:0]             cleanQ;
  logic [7:0]             cleanD;
  logic [7:0][cCntW-1:0]  stableQ;
  logic [7:0][cCntW-1:0]  stableD;

  logic                   dipChgQ;
  logic [3:0]             pushPressQ;
  logic [3:0]             pushReleaseQ;
  logic [3:0][cHoldW-1:0] holdCnt;
  logic [3:0]             holdQ;

  // Two-flop synchronisers for all eight asynchronous pads.
  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      dipMeta  <= '0;
      dipSync  <= '0;
      pushMeta <= cPushIdle;
      pushSync <= cPushIdle;
    end else begin
      dipMeta  <= iUserDipSw;
      dipSync  <= dipMeta;
      pushMeta <= iUserPushSw;
      pushSync <= pushMeta;
    end
  end

  assign pushLevel = pPUSH_ACT_LOW ? ~pushSync : pushSync;
  assign sampled   = {pushLevel, dipSync};

  // Free-running prescaler that produces the debounce sample tick.
  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      divCount <= '0;
    end else if (divCount == cDivLast) begin
      divCount <= '0;
    end else begin
      divCount <= divCount + 1'b1;
    end
  end

  assign tick = (divCount == cDivLast);

  // Per-bit debounce: a differing input must be seen on pSTABLE_TICKS ticks in a row.
  always_comb begin
    cleanD  = cleanQ;
    stableD = stableQ;
    for (int i = 0; i < 8; i++) begin
      if (sampled[i] == cleanQ[i]) begin
        stableD[i] = '0;
      end else if (tick) begin
        if (stableQ[i] == cCntLast) begin
          cleanD[i]  = sampled[i];
          stableD[i] = '0;
        end else begin
          stableD[i] = stableQ[i] + 1'b1;
        end
      end
    end
  end

  // Clean state, counters and edge pulses all update on the same edge.
  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      cleanQ       <= '0;
      stableQ      <= '0;
      dipChgQ      <= 1'b0;
      pushPressQ   <= '0;
      pushReleaseQ <= '0;
    end else begin
      cleanQ       <= cleanD;
      stableQ      <= stableD;
      dipChgQ      <= |(cleanD[3:0] ^ cleanQ[3:0]);
      pushPressQ   <= cleanD[7:4] & ~cleanQ[7:4];
      pushReleaseQ <= ~cleanD[7:4] & cleanQ[7:4];
    end
  end

  // Long-press tracking: saturating tick count while pressed, hold level drops with the release.
  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      holdCnt <= '0;
      holdQ   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!cleanQ[4+i]) begin
          holdCnt[i] <= '0;
        end else if (tick && (holdCnt[i] != cHoldMax)) begin
          holdCnt[i] <= holdCnt[i] + 1'b1;
        end

        if (!cleanD[4+i]) begin
          holdQ[i] <= 1'b0;
        end else if (cleanQ[4+i] && tick && (holdCnt[i] == cHoldLast)) begin
          holdQ[i] <= 1'b1;
        end
      end
    end
  end

  assign oDipSw       = cleanQ[3:0];
  assign oDipChg      = dipChgQ;
  assign oPushSw      = cleanQ[7:4];
  assign oPushPress   = pushPressQ;
  assign oPushRelease = pushReleaseQ;
  assign oPushHold    = holdQ;

endmodule

// File: tb/tb_user_sw_debouncer.sv
// Self-checking bench for user_sw_debouncer with a short tick (4 cycles),
// 3 stable ticks and a 5-tick long press. Hand-written sequences cover
// latency, glitch rejection, hold timing, simultaneous DIP changes and reset
// mid-debounce; a table of steady-state vectors closes the run.
module tb_user_sw_debouncer;

  localparam int cTick   = 4;
  localparam int cStable = 3;
  localparam int cHold   = 5;

  typedef struct {
    logic [3:0] dip;
    logic [3:0] pushPad;
    logic [3:0] expDip;
    logic [3:0] expPush;
    logic [3:0] expHold;
  } vecT;

  typedef struct {
    logic [3:0] dip;
    logic [3:0] push;
    logic [3:0] hold;
  } expT;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  dipPads;
  logic [3:0]  pushPads;
  logic [3:0]  oDipSw;
  logic        oDipChg;
  logic [3:0]  oPushSw;
  logic [3:0]  oPushPress;
  logic [3:0]  oPushRelease;
  logic [3:0]  oPushHold;
  logic [20:0] allOut;

  int  testsRun = 0;
  int  testsFailed = 0;
  expT sbQueue[$];
  vecT vecs[7];

  user_sw_debouncer #(
    .pTICK_DIV    (cTick),
    .pSTABLE_TICKS(cStable),
    .pHOLD_TICKS  (cHold),
    .pPUSH_ACT_LOW(1'b1)
  ) dut (
    .iSysClk     (clk),
    .iSysRstn    (rstn),
    .iUserDipSw  (dipPads),
    .iUserPushSw (pushPads),
    .oDipSw      (oDipSw),
    .oDipChg     (oDipChg),
    .oPushSw     (oPushSw),
    .oPushPress  (oPushPress),
    .oPushRelease(oPushRelease),
    .oPushHold   (oPushHold)
  );

  // 100 MHz bench clock.
  always #5 clk = ~clk;

  assign allOut = {oDipSw, oDipChg, oPushSw, oPushPress, oPushRelease, oPushHold};

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vecT v);
    expT e;
    @(negedge clk);
    dipPads  = v.dip;
    pushPads = v.pushPad;
    e.dip    = v.expDip;
    e.push   = v.expPush;
    e.hold   = v.expHold;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    expT e;
    if (sbQueue.size() == 0) begin
      checkVal($sformatf("vec%0d_queue", idx), 32'd0, 32'd1);
    end else begin
      e = sbQueue.pop_front();
      checkVal($sformatf("vec%0d_dip", idx), 32'(oDipSw), 32'(e.dip));
      checkVal($sformatf("vec%0d_push", idx), 32'(oPushSw), 32'(e.push));
      checkVal($sformatf("vec%0d_hold", idx), 32'(oPushHold), 32'(e.hold));
      checkVal($sformatf("vec%0d_pulses", idx), 32'({oDipChg, oPushPress, oPushRelease}), 32'd0);
    end
  endtask

  // Hard stop in case any sequence wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int idleHits;
    int riseAt, pressAt, pressCnt, holdAt, other;
    int glitchHits;
    int fallAt, relAt, relCnt, holdClrAt;
    logic [3:0] prevDip;
    int dipSteps, stepAt, chgCnt, chgAt;
    int freshAt;

    vecs[0] = '{dip: 4'h0, pushPad: 4'hF, expDip: 4'h0, expPush: 4'h0, expHold: 4'h0};
    vecs[1] = '{dip: 4'hA, pushPad: 4'hE, expDip: 4'hA, expPush: 4'h1, expHold: 4'h1};
    vecs[2] = '{dip: 4'h5, pushPad: 4'hC, expDip: 4'h5, expPush: 4'h3, expHold: 4'h3};
    vecs[3] = '{dip: 4'hF, pushPad: 4'h3, expDip: 4'hF, expPush: 4'hC, expHold: 4'hC};
    vecs[4] = '{dip: 4'h0, pushPad: 4'h0, expDip: 4'h0, expPush: 4'hF, expHold: 4'hF};
    vecs[5] = '{dip: 4'h9, pushPad: 4'hF, expDip: 4'h9, expPush: 4'h0, expHold: 4'h0};
    vecs[6] = '{dip: 4'h6, pushPad: 4'hA, expDip: 4'h6, expPush: 4'h5, expHold: 4'h5};

    // Reset with switches released, then idle.
    dipPads  = 4'h0;
    pushPads = 4'hF;
    rstn     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_outputs", 32'(allOut), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idleHits = 0;
    repeat (100) begin
      stepCycle();
      if (allOut != '0) idleHits++;
    end
    checkVal("idle_after_reset", idleHits, 0);

    // Press push 0 and keep it held until the long-press level rises.
    @(negedge clk);
    pushPads[0] = 1'b0;
    riseAt = -1; pressAt = -1; pressCnt = 0; holdAt = -1; other = 0;
    for (int k = 1; k <= 60 && holdAt < 0; k++) begin
      stepCycle();
      if (oPushSw[0] && riseAt < 0) riseAt = k;
      if (oPushPress[0]) begin
        pressCnt++;
        if (pressAt < 0) pressAt = k;
      end
      if (oPushHold[0] && holdAt < 0) holdAt = k;
      if (oDipSw != 0 || oDipChg || oPushSw[3:1] != 0 || oPushPress[3:1] != 0 ||
          oPushRelease != 0 || oPushHold[3:1] != 0) other++;
    end
    checkVal("press_latency_11_14", 32'(riseAt >= 11 && riseAt <= 14), 32'd1);
    checkVal("press_pulse_cycle", pressAt, riseAt);
    checkVal("press_pulse_count", pressCnt, 1);
    checkVal("press_other_bits_quiet", other, 0);
    checkVal("hold_delay_cycles", holdAt - riseAt, 20);

    // Six-cycle glitch on push 1 must be rejected.
    @(negedge clk);
    pushPads[1] = 1'b0;
    glitchHits = 0;
    for (int k = 1; k <= 40; k++) begin
      stepCycle();
      if (oPushSw[1] || oPushPress[1] || oPushRelease[1]) glitchHits++;
      if (k == 6) begin
        @(negedge clk);
        pushPads[1] = 1'b1;
      end
    end
    checkVal("glitch_rejected", glitchHits, 0);
    checkVal("push0_still_held", 32'({oPushSw[0], oPushHold[0]}), 32'd3);

    // Release push 0: release pulse and hold clear land with the falling level.
    @(negedge clk);
    pushPads[0] = 1'b1;
    fallAt = -1; relAt = -1; relCnt = 0; holdClrAt = -1;
    for (int k = 1; k <= 40; k++) begin
      stepCycle();
      if (!oPushSw[0] && fallAt < 0) fallAt = k;
      if (oPushRelease[0]) begin
        relCnt++;
        if (relAt < 0) relAt = k;
      end
      if (!oPushHold[0] && holdClrAt < 0) holdClrAt = k;
    end
    checkVal("release_latency_11_14", 32'(fallAt >= 11 && fallAt <= 14), 32'd1);
    checkVal("release_pulse_cycle", relAt, fallAt);
    checkVal("release_pulse_count", relCnt, 1);
    checkVal("hold_clear_cycle", holdClrAt, fallAt);

    // Two DIP bits change together: one step, one change pulse.
    @(negedge clk);
    dipPads = 4'b0101;
    prevDip = oDipSw;
    dipSteps = 0; stepAt = -1; chgCnt = 0; chgAt = -2;
    for (int k = 1; k <= 40; k++) begin
      stepCycle();
      if (oDipSw != prevDip) begin
        dipSteps++;
        stepAt  = k;
        prevDip = oDipSw;
      end
      if (oDipChg) begin
        chgCnt++;
        chgAt = k;
      end
    end
    checkVal("dip_single_step", dipSteps, 1);
    checkVal("dip_chg_count", chgCnt, 1);
    checkVal("dip_chg_cycle", chgAt, stepAt);
    checkVal("dip_final_value", 32'(oDipSw), 32'h5);

    // Reset in the middle of a push 2 debounce, then a full fresh debounce.
    @(negedge clk);
    pushPads[2] = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkVal("async_reset_clear", 32'(allOut), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    freshAt = -1;
    for (int k = 1; k <= 40 && freshAt < 0; k++) begin
      stepCycle();
      if (oPushSw[2]) freshAt = k;
    end
    checkVal("fresh_debounce_after_reset", freshAt, 12);

    // Steady-state vector table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      repeat (40) stepCycle();
      checkOutput(i);
    end
    checkVal("scoreboard_drained", sbQueue.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
